// File: rtl/ceespu_pc_ctrl_if.sv
// rtl/ceespu_pc_ctrl_if.sv - request/PC-control bundle between execute/hazard logic and ceespu_pc_ctrl
interface ceespu_pc_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              I_stall_req;
    logic              I_branch;
    logic [ADDR_W-1:0] I_branchAddress;
    logic              I_reti;
    logic              I_irq;
    logic [ADDR_W-1:0] I_resume_pc;
    logic              O_pc_rst;
    logic              O_pc_branch;
    logic [ADDR_W-1:0] O_pc_branchAddress;
    logic              O_pc_stall;
    logic              O_flush;
    logic              O_irq_ack;
    logic              O_in_isr;
    logic [ADDR_W-1:0] O_epc;

    modport master (
        output I_stall_req, I_branch, I_branchAddress, I_reti, I_irq, I_resume_pc,
        input  O_pc_rst, O_pc_branch, O_pc_branchAddress, O_pc_stall, O_flush,
               O_irq_ack, O_in_isr, O_epc
    );

    modport slave (
        input  I_stall_req, I_branch, I_branchAddress, I_reti, I_irq, I_resume_pc,
        output O_pc_rst, O_pc_branch, O_pc_branchAddress, O_pc_stall, O_flush,
               O_irq_ack, O_in_isr, O_epc
    );
endinterface

// File: rtl/ceespu_pc_ctrl.sv
// rtl/ceespu_pc_ctrl.sv - PC redirect arbiter with pipeline flush; interrupt/RETI logic enabled by CEESPU_IRQ_EN
module ceespu_pc_ctrl #(
    parameter int                ADDR_W       = 14,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = 14'h0004,
    parameter int                FLUSH_CYCLES = 2
) (
    input logic             I_clk,
    input logic             I_rst_n,
    ceespu_pc_ctrl_if.slave bus
);

    generate
        if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
            $error("FLUSH_CYCLES must be at least 1");
        end
    endgenerate

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        rst_sync_q;
    logic              pc_rst;
    logic              branch_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ack_q, ack_d;
    logic              isr_q, isr_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              take;
    logic [ADDR_W-1:0] target;

    assign pc_rst = ~rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        target  = addr_q;
        ack_d   = 1'b0;
        isr_d   = isr_q;
        epc_d   = epc_q;
        case (state_q)
            ST_RUN: begin
                if (!pc_rst) begin
                    if (bus.I_branch) begin
                        take   = 1'b1;
                        target = bus.I_branchAddress;
                    end
`ifdef CEESPU_IRQ_EN
                    else if (bus.I_reti && isr_q) begin
                        take   = 1'b1;
                        target = epc_q;
                        isr_d  = 1'b0;
                    end else if (bus.I_irq && !isr_q && !bus.I_stall_req) begin
                        take   = 1'b1;
                        target = IRQ_VECTOR;
                        epc_d  = bus.I_resume_pc;
                        isr_d  = 1'b1;
                        ack_d  = 1'b1;
                    end
`endif
                    if (take) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                // Requests seen here come from flushed instructions and are dropped.
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rst_sync_q <= 2'b00;
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            branch_q   <= 1'b0;
            addr_q     <= '0;
            ack_q      <= 1'b0;
            isr_q      <= 1'b0;
            epc_q      <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            branch_q   <= take;
            if (take) begin
                addr_q <= target;
            end
            ack_q      <= ack_d;
            isr_q      <= isr_d;
            epc_q      <= epc_d;
        end
    end

`ifndef CEESPU_IRQ_EN
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{bus.I_irq, bus.I_reti, bus.I_resume_pc};
`endif

    assign bus.O_pc_rst           = pc_rst;
    assign bus.O_pc_branch        = branch_q;
    assign bus.O_pc_branchAddress = addr_q;
    assign bus.O_flush            = (state_q == ST_FLUSH);
    assign bus.O_pc_stall         = bus.I_stall_req & ~bus.O_flush & ~pc_rst;
    assign bus.O_irq_ack          = ack_q;
    assign bus.O_in_isr           = isr_q;
    assign bus.O_epc              = epc_q;

endmodule

// File: doc/ceespu_pc_ctrl.md
# ceespu_pc_ctrl

Program-counter sequencer for the ceespu fetch stage. It sits between execute/hazard logic and `ceespu_pc` and drives that module's `I_rst`, `I_branch`, `I_branchAddress` and `I_stall`. It arbitrates three redirect sources: taken branch, interrupt entry and return-from-interrupt. After every redirect it runs a fixed-length pipeline flush and saves and restores the exception PC.

## Interface
- `ADDR_W`, 14 — PC width in bits.
- `IRQ_VECTOR`, 14'h0004 — interrupt entry address.
- `FLUSH_CYCLES`, 2 — cycles `O_flush` stays high after each redirect; must be ≥1, elaboration error otherwise.

- `I_clk`  in  1  — clock, rising edge.
- `I_rst_n`  in  1  — reset, asynchronous, active-low.
- `I_stall_req`  in  1  — hazard-unit stall request.
- `I_branch`  in  1  — taken branch from execute.
- `I_branchAddress`  in  ADDR_W  — branch target.
- `I_reti`  in  1  — return-from-interrupt executed.
- `I_irq`  in  1  — level-sensitive interrupt request.
- `I_resume_pc`  in  ADDR_W  — address of the oldest uncommitted instruction.
- `O_pc_rst`  out  1  — synchronous reset to the PC.
- `O_pc_branch`  out  1  — PC load strobe.
- `O_pc_branchAddress`  out  ADDR_W  — PC load value.
- `O_pc_stall`  out  1  — PC hold.
- `O_flush`  out  1  — invalidate fetch and decode stages.
- `O_irq_ack`  out  1  — one-cycle interrupt accept pulse.
- `O_in_isr`  out  1  — inside interrupt handler; further interrupts masked.
- `O_epc`  out  ADDR_W  — saved return address.

## Operation
- **Reset values** (while `I_rst_n`=0): `O_pc_rst`=1; all other outputs 0; state RUN; flush counter 0.
- **Reset release:** `O_pc_rst` is a 2-flop synchronizer output. It falls on the 2nd rising edge after `I_rst_n` rises. All requests are ignored while `O_pc_rst`=1.
- **State machine:** states are RUN and FLUSH.
- **Request acceptance in RUN**, at a rising edge, in priority order:
  1. `I_branch` → target `I_branchAddress`. A simultaneous `I_reti` or `I_irq` is dropped or left pending.
  2. `I_reti` with `O_in_isr`=1 → target `O_epc`; `O_in_isr`←0. `I_reti` with `O_in_isr`=0 is ignored and causes no redirect.
  3. `I_irq` with `O_in_isr`=0 and `I_stall_req`=0 → target `IRQ_VECTOR`; `O_epc`←`I_resume_pc`; `O_in_isr`←1; `O_irq_ack`=1 for one cycle.
- **On an accepted redirect:**
  - `O_pc_branch`=1 and `O_pc_branchAddress`=target, both registered, for exactly one cycle.
  - State→FLUSH; counter←`FLUSH_CYCLES`-1.
- **FLUSH:**
  - `O_flush`=1.
  - The counter decrements each edge; at 0 the state returns to RUN.
  - Any `I_branch` or `I_reti` sampled while in FLUSH is discarded, since it comes from a flushed instruction.
  - `I_irq` stays pending because it is level-sensitive.
- **Stall:** `O_pc_stall` = `I_stall_req` & ~`O_flush` & ~`O_pc_rst`. It is combinational and is the only non-registered output.
- **Reset mid-operation:** asserting `I_rst_n`=0 in any state immediately forces the reset values. It aborts any flush, and the saved `O_epc` is lost.
- `O_pc_branchAddress` holds its last value when `O_pc_branch`=0.

## Timing
- Redirect latency: request sampled at edge E → `O_pc_branch` high from E to E+1 → PC loads the target at E+1.
- `O_flush` is high for exactly `FLUSH_CYCLES` cycles, starting at E.
- The first new request can be accepted at the first edge after `O_flush` falls.
- `O_irq_ack` is coincident with the `O_pc_branch` of the interrupt entry.
- `O_in_isr` and `O_epc` update at E.

## Configuration
- **`CEESPU_IRQ_EN` defined:** interrupt and RETI logic as described above.
- **`CEESPU_IRQ_EN` undefined:**
  - `I_irq`, `I_reti` and `I_resume_pc` are ignored.
  - `O_irq_ack`, `O_in_isr` and `O_epc` are tied to 0.
  - Only branch redirects and the flush sequence remain.

## Test plan
- **Reset:** hold `I_rst_n`=0, then release → `O_pc_rst`=1 until the 2nd edge after release; all other outputs 0; `O_pc_stall`=0 even with `I_stall_req`=1.
- **Branch:** `I_branch`=1 with `I_branchAddress`=14'h0123 for one cycle → `O_pc_branch`=1 with 14'h0123 for one cycle; `O_flush`=1 for 2 cycles; a second `I_branch` sampled during flush produces no redirect.
- **Interrupt entry and return:**
  - `I_irq`=1 with `I_resume_pc`=14'h0040 → redirect to 14'h0004; `O_irq_ack` pulse; `O_epc`=14'h0040; `O_in_isr`=1.
  - `I_irq` held high → no re-entry.
  - `I_reti` → redirect to 14'h0040; `O_in_isr`=0.
- **Priority:**
  - `I_branch`, `I_reti` and `I_irq` all asserted in the same cycle → only the branch is taken.
  - The interrupt is taken after the flush if `I_irq` is still high.
  - `I_irq` with `I_stall_req`=1 → not taken until the stall clears.
- **Abort:** `I_rst_n` pulsed low during FLUSH with `O_in_isr`=1 → all outputs return to reset values immediately; no redirect after release.
